// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_pkg : opcode map shared by decoder, immediate generator, hazard control
// Rev 1.0
// ---------------------------------------------------------------------------
package core_pkg;

  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_ANDI = 5'b00101;
  localparam logic [4:0] OP_ORI  = 5'b00111;
  localparam logic [4:0] OP_XORI = 5'b01001;
  localparam logic [4:0] OP_SLLI = 5'b01011;
  localparam logic [4:0] OP_SRLI = 5'b01101;
  localparam logic [4:0] OP_LUI  = 5'b01110;
  localparam logic [4:0] OP_LW   = 5'b01111;
  localparam logic [4:0] OP_SW   = 5'b10000;
  localparam logic [4:0] OP_BLT  = 5'b10001;
  localparam logic [4:0] OP_BEQ  = 5'b10010;
  localparam logic [4:0] OP_JAL  = 5'b10011;
  localparam logic [4:0] OP_JALR = 5'b10100;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_ERR   = 2'd2
  } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_detect : source-register use decode and load-use compare (comb only)
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_detect
  import core_pkg::*;
(
  input  logic [31:0] IFIDIns,
  input  logic [4:0]  IDEXOpcode,
  input  logic [4:0]  IDEXRd,
  output logic        LoadUse
);

  logic [4:0] w_op;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_unused;

  assign w_op     = IFIDIns[4:0];
  assign w_rs1    = IFIDIns[19:15];
  assign w_rs2    = IFIDIns[24:20];
  assign w_unused = ^{IFIDIns[31:25], IFIDIns[14:5]};

  always_comb begin
    w_use_rs1 = 1'b1;
    w_use_rs2 = 1'b1;
    case (w_op)
      OP_LUI, OP_JAL: w_use_rs1 = 1'b0;
      default:        w_use_rs1 = 1'b1;
    endcase
    // Unlisted opcodes conservatively count rs2 as a source.
    case (w_op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
      OP_LUI, OP_LW, OP_JAL, OP_JALR: w_use_rs2 = 1'b0;
      default:                        w_use_rs2 = 1'b1;
    endcase
  end

  assign LoadUse = (IDEXOpcode == OP_LW) && (IDEXRd != 5'd0) &&
                   ((w_use_rs1 && (w_rs1 == IDEXRd)) ||
                    (w_use_rs2 && (w_rs2 == IDEXRd)));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : pipeline enables/flushes, memory-wait FSM, stall counter
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IFIDIns,
  input  logic [4:0]       IDEXOpcode,
  input  logic [4:0]       IDEXRd,
  input  logic             RedirectEX,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_timeout = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         r_state;
  hz_state_e         w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_freeze;
  logic              w_load_use;

  hazard_detect u_hazard_detect (
    .IFIDIns    (IFIDIns),
    .IDEXOpcode (IDEXOpcode),
    .IDEXRd     (IDEXRd),
    .LoadUse    (w_load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_freeze = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (MemReq && !MemReady) begin
          w_freeze = 1'b1;
          w_next   = ST_MWAIT;
        end
      end
      ST_MWAIT: begin
        if (MemReady) begin
          w_next = ST_RUN;
        end else begin
          w_freeze = 1'b1;
          if (r_wait_cnt == c_timeout) w_next = ST_ERR;
        end
      end
      ST_ERR:  w_freeze = 1'b1;
      default: w_next   = ST_RUN;
    endcase
  end

  // Counter value k means the k-th MWAIT cycle is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_RUN && w_next == ST_MWAIT) begin
      r_wait_cnt <= WAIT_W'(1);
    end else if (r_state == ST_MWAIT && w_next == ST_MWAIT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else if (w_next == ST_RUN) begin
      r_wait_cnt <= '0;
    end
  end

  // A held EX stage re-presents RedirectEX/LoadUse, so freeze masks them.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    EXMEMWrite = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    if (!rst_n || w_freeze) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
    end else if (RedirectEX) begin
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
    end else if (w_load_use) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXFlush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!PCWrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign StallCnt = r_stall_cnt;
  assign MemErr   = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed stimulus, cycle-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 3;
  localparam int MAXC = (1 << CW) - 1;

  localparam logic [4:0] ADDI = 5'b00010, ANDI = 5'b00101, ORI  = 5'b00111,
                         XORI = 5'b01001, SLLI = 5'b01011, SRLI = 5'b01101,
                         LUI  = 5'b01110, LW   = 5'b01111, SW   = 5'b10000,
                         JAL  = 5'b10011, JALR = 5'b10100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   IFIDIns = '0;
  logic [4:0]    IDEXOpcode = '0;
  logic [4:0]    IDEXRd = '0;
  logic          RedirectEX = 1'b0;
  logic          MemReq = 1'b0;
  logic          MemReady = 1'b0;
  logic          PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic          IFIDFlush, IDEXFlush, MemErr;
  logic [CW-1:0] StallCnt;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IFIDIns    (IFIDIns),
    .IDEXOpcode (IDEXOpcode),
    .IDEXRd     (IDEXRd),
    .RedirectEX (RedirectEX),
    .MemReq     (MemReq),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .IFIDWrite  (IFIDWrite),
    .IDEXWrite  (IDEXWrite),
    .EXMEMWrite (EXMEMWrite),
    .IFIDFlush  (IFIDFlush),
    .IDEXFlush  (IDEXFlush),
    .MemErr     (MemErr),
    .StallCnt   (StallCnt)
  );

  always #5 clk = ~clk;

  // Reference model: pend counts consecutive unserved memory cycles so far.
  int   m_pend = 0;
  bit   m_err  = 1'b0;
  int   m_scnt = 0;
  logic m_lu, m_frz;
  logic [6:0] m_out;

  function automatic logic load_use(input logic [31:0] ins, input logic [4:0] op,
                                    input logic [4:0] rd);
    logic [4:0] iop;
    logic u1, u2;
    iop = ins[4:0];
    u1 = !(iop inside {LUI, JAL});
    u2 = !(iop inside {ADDI, ANDI, ORI, XORI, SLLI, SRLI, LUI, LW, JAL, JALR});
    return (op == LW) && (rd != 0) &&
           ((u1 && ins[19:15] == rd) || (u2 && ins[24:20] == rd));
  endfunction

  always_comb begin
    m_lu  = load_use(IFIDIns, IDEXOpcode, IDEXRd);
    m_frz = m_err || (m_pend > 0 && !MemReady) || (m_pend == 0 && MemReq && !MemReady);
    // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MemErr}
    if (!rst_n)          m_out = 7'b0000000;
    else if (m_frz)      m_out = {6'b000000, m_err};
    else if (RedirectEX) m_out = 7'b1111110;
    else if (m_lu)       m_out = 7'b0011010;
    else                 m_out = 7'b1111000;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 0;
      m_err  <= 1'b0;
      m_scnt <= 0;
    end else begin
      if (!m_err) begin
        if (m_frz) begin
          m_pend <= m_pend + 1;
          if (m_pend + 1 == TO + 1) m_err <= 1'b1;
        end else begin
          m_pend <= 0;
        end
      end
      if (!m_out[6] && m_scnt < MAXC) m_scnt <= m_scnt + 1;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MemErr} !== m_out ||
        StallCnt !== CW'(m_scnt)) begin
      errors++;
      $display("FAIL model t=%0t ctl=%b want=%b stallcnt=%0d want=%0d", $time,
               {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MemErr},
               m_out, StallCnt, m_scnt);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    logic [31:0] v;
    v = '0;
    v[4:0]   = op;
    v[19:15] = rs1;
    v[24:20] = rs2;
    return v;
  endfunction

  // Apply one cycle of inputs just after the edge, then let outputs settle.
  task automatic cyc(input logic [31:0] ins, input logic [4:0] op, input logic [4:0] rd,
                     input logic redir, input logic req, input logic rdy);
    @(posedge clk);
    #1;
    IFIDIns = ins; IDEXOpcode = op; IDEXRd = rd;
    RedirectEX = redir; MemReq = req; MemReady = rdy;
    #1;
  endtask

  task automatic idle();
    cyc(mk(ADDI, 1, 0), ADDI, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    IFIDIns = mk(ADDI, 1, 0); IDEXOpcode = ADDI; IDEXRd = 0;
    RedirectEX = 0; MemReq = 0; MemReady = 0;
    #1;
    chk("rst_memerr", MemErr, 0);
    chk("rst_stallcnt", StallCnt, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_idexflush", IDEXFlush, 0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_pcwrite", PCWrite, 0);
    chk("reset_stallcnt", StallCnt, 0);
    #1 rst_n = 1'b1;

    // Load-use on rs1 stalls exactly one cycle.
    cyc(mk(ADDI, 5, 0), LW, 5'd5, 0, 0, 0);
    chk("lu_pcwrite", PCWrite, 0);
    chk("lu_ifidwrite", IFIDWrite, 0);
    chk("lu_idexflush", IDEXFlush, 1);
    chk("lu_idexwrite", IDEXWrite, 1);
    cyc(mk(ADDI, 5, 0), ADDI, 5'd0, 0, 0, 0);
    chk("lu_after_pcwrite", PCWrite, 1);
    chk("lu_stallcnt", StallCnt, 1);
    cyc(mk(ADDI, 0, 0), LW, 5'd0, 0, 0, 0);
    chk("lu_rd0_pcwrite", PCWrite, 1);
    cyc(mk(LUI, 5, 5), LW, 5'd5, 0, 0, 0);
    chk("lu_lui_pcwrite", PCWrite, 1);

    // rs2 decode: sw reads rs2, addi does not.
    cyc(mk(SW, 1, 7), LW, 5'd7, 0, 0, 0);
    chk("rs2_sw_pcwrite", PCWrite, 0);
    cyc(mk(ADDI, 1, 7), LW, 5'd7, 0, 0, 0);
    chk("rs2_addi_pcwrite", PCWrite, 1);
    chk("rs2_stallcnt", StallCnt, 2);

    // Redirect beats load-use.
    cyc(mk(ADDI, 5, 0), LW, 5'd5, 1, 0, 0);
    chk("redir_ifidflush", IFIDFlush, 1);
    chk("redir_idexflush", IDEXFlush, 1);
    chk("redir_pcwrite", PCWrite, 1);
    idle();
    chk("redir_stallcnt", StallCnt, 2);

    reset_pulse();

    // Memory wait of 3 cycles with a redirect held against the freeze.
    repeat (3) begin
      cyc(mk(ADDI, 1, 0), ADDI, 5'd0, 1, 1, 0);
      chk("mw_pcwrite", PCWrite, 0);
      chk("mw_exmemwrite", EXMEMWrite, 0);
      chk("mw_ifidflush", IFIDFlush, 0);
    end
    cyc(mk(ADDI, 1, 0), ADDI, 5'd0, 1, 1, 1);
    chk("mw_ready_pcwrite", PCWrite, 1);
    chk("mw_ready_exmemwrite", EXMEMWrite, 1);
    chk("mw_ready_ifidflush", IFIDFlush, 1);
    idle();
    chk("mw_stallcnt", StallCnt, 3);
    chk("mw_run_pcwrite", PCWrite, 1);

    reset_pulse();

    // Timeout: one RUN cycle plus TO MWAIT cycles, then ERR.
    repeat (5) cyc(mk(ADDI, 1, 0), ADDI, 5'd0, 0, 1, 0);
    chk("to_pre_memerr", MemErr, 0);
    cyc(mk(ADDI, 1, 0), ADDI, 5'd0, 0, 1, 0);
    chk("to_memerr", MemErr, 1);
    chk("to_stallcnt", StallCnt, 5);
    cyc(mk(ADDI, 1, 0), ADDI, 5'd0, 0, 1, 1);
    chk("err_ready_pcwrite", PCWrite, 0);
    chk("err_sticky", MemErr, 1);
    repeat (4) cyc(mk(ADDI, 1, 0), ADDI, 5'd0, 0, 1, 0);
    chk("sat_stallcnt", StallCnt, 7);

    reset_pulse();
    idle();
    chk("post_rst_pcwrite", PCWrite, 1);
    chk("post_rst_memerr", MemErr, 0);
    idle();

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
